// File: rtl/alu_sequencial.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops, plus iterative shift-add
// multiply and restoring divide that each take WIDTH clocks.
module alu_sequencial #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [5:0]       ALU_Ctrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result_Hi,
    output logic             Zero,
    output logic             Div_Zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             div_zero_q, div_zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] simple_s;
    logic             slt_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] mul_hi_s, mul_lo_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH+1:0] div_diff_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] div_hi_s, div_lo_s;

    // Single-cycle operations; unknown codes fall back to add.
    always_comb begin
        slt_s    = ($signed(A) < $signed(B));
        simple_s = A + B;
        case (ALU_Ctrl)
            6'd1:    simple_s = A - B;
            6'd4:    simple_s = A | B;
            6'd5:    simple_s = A & B;
            6'd6:    simple_s = ~A;
            6'd7:    simple_s = {{(WIDTH-1){1'b0}}, slt_s};
            default: simple_s = A + B;
        endcase
    end

    // One multiply / divide iteration. hi_q:lo_q holds the partial product
    // (multiplier shifted out of lo_q) or the remainder:quotient pair.
    always_comb begin
        mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_hi_s    = mul_sum_s[WIDTH:1];
        mul_lo_s    = {mul_sum_s[0], lo_q[WIDTH-1:1]};
        div_shift_s = {hi_q, lo_q[WIDTH-1]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, opnd_q};
        div_ge_s    = ~div_diff_s[WIDTH+1];
        div_hi_s    = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
        div_lo_s    = {lo_q[WIDTH-2:0], div_ge_s};
    end

    // Next-state and result-register update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        div_zero_d  = div_zero_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (ALU_Ctrl == 6'd2 || (ALU_Ctrl == 6'd3 && B != {WIDTH{1'b0}})) begin
                        state_d = (ALU_Ctrl == 6'd2) ? ST_MUL : ST_DIV;
                        cnt_d   = CNT_ZERO;
                        hi_d    = {WIDTH{1'b0}};
                        lo_d    = A;
                        opnd_d  = B;
                    end else if (ALU_Ctrl == 6'd3) begin
                        result_d    = {WIDTH{1'b1}};
                        result_hi_d = A;
                        zero_d      = 1'b0;
                        div_zero_d  = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        result_d    = simple_s;
                        result_hi_d = {WIDTH{1'b0}};
                        zero_d      = (simple_s == {WIDTH{1'b0}});
                        div_zero_d  = 1'b0;
                        done_d      = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                hi_d  = (state_q == ST_MUL) ? mul_hi_s : div_hi_s;
                lo_d  = (state_q == ST_MUL) ? mul_lo_s : div_lo_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    result_d    = lo_d;
                    result_hi_d = hi_d;
                    zero_d      = (lo_d == {WIDTH{1'b0}});
                    div_zero_d  = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset mid-iteration aborts silently.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            hi_q        <= {WIDTH{1'b0}};
            lo_q        <= {WIDTH{1'b0}};
            opnd_q      <= {WIDTH{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            result_hi_q <= {WIDTH{1'b0}};
            zero_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            div_zero_q  <= div_zero_d;
            done_q      <= done_d;
        end
    end

    assign Busy      = (state_q != ST_IDLE);
    assign Done      = done_q;
    assign Result    = result_q;
    assign Result_Hi = result_hi_q;
    assign Zero      = zero_q;
    assign Div_Zero  = div_zero_q;

endmodule

// File: tb/tb_alu_sequencial.sv
// Self-checking bench for alu_sequencial: vector table, random ops against a
// behavioural model, handshake and mid-operation reset sequences.
module tb_alu_sequencial;

    localparam int W = 32;

    logic         Clock;
    logic         Reset_n;
    logic         Start;
    logic [5:0]   ALU_Ctrl;
    logic [W-1:0] A, B;
    logic         Busy, Done, Zero, Div_Zero;
    logic [W-1:0] Result, Result_Hi;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0]   code;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         dz;
        int           lat;
        int           busy;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs [0:15];

    alu_sequencial #(.WIDTH(W)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .ALU_Ctrl  (ALU_Ctrl),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .Result_Hi (Result_Hi),
        .Zero      (Zero),
        .Div_Zero  (Div_Zero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lat_of(input logic [5:0] code, input logic [W-1:0] b);
        return (code == 6'd2 || (code == 6'd3 && b != '0)) ? W + 1 : 1;
    endfunction

    function automatic exp_t mk_exp(input logic [5:0] code, input logic [W-1:0] b,
                                    input logic [W-1:0] res, input logic [W-1:0] hi, input logic dz);
        exp_t e;
        e.res  = res;
        e.hi   = hi;
        e.zero = (res == '0);
        e.dz   = dz;
        e.lat  = lat_of(code, b);
        e.busy = e.lat - 1;
        return e;
    endfunction

    function automatic exp_t model(input logic [5:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [W-1:0]   r, h;
        logic           dz;
        h  = '0;
        dz = 1'b0;
        case (code)
            6'd1: r = a - b;
            6'd2: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; h = p[2*W-1:W]; end
            6'd3: begin
                if (b == '0) begin r = '1; h = a; dz = 1'b1; end
                else begin r = a / b; h = a % b; end
            end
            6'd4: r = a | b;
            6'd5: r = a & b;
            6'd6: r = ~a;
            6'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = a + b;
        endcase
        return mk_exp(code, b, r, h, dz);
    endfunction

    task automatic compare_out(input string name, input int lat, input int busy);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({name, "_unexpected_done"}, 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        chk({name, "_result"}, Result, e.res);
        chk({name, "_result_hi"}, Result_Hi, e.hi);
        chk({name, "_zero"}, Zero, e.zero);
        chk({name, "_div_zero"}, Div_Zero, e.dz);
        chk({name, "_latency"}, lat, e.lat);
        chk({name, "_busy_cycles"}, busy, e.busy);
        chk({name, "_busy_in_done"}, Busy, 1'b0);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge whose Done was seen.
    task automatic run_op(input string name, input logic [5:0] code,
                          input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        int lat;
        int busy;
        sb_q.push_back(e);
        Start = 1'b1; ALU_Ctrl = code; A = a; B = b;
        @(posedge Clock); #1;
        Start = 1'b0; A = $urandom; B = $urandom; ALU_Ctrl = 6'($urandom);
        lat = 1;
        busy = 0;
        while (!Done && lat < 3 * W) begin
            if (Busy) busy++;
            @(posedge Clock); #1;
            lat++;
        end
        if (!Done) begin
            chk({name, "_timeout"}, 64'd0, 64'd1);
            void'(sb_q.pop_front());
        end else begin
            compare_out(name, lat, busy);
        end
    endtask

    initial begin
        int lat;
        int busy;
        int dones;
        logic [5:0]   rc;
        logic [W-1:0] ra, rb;

        vecs[0]  = '{6'd0, 32'd5,          32'd7,          32'd12,         32'd0,          1'b0};
        vecs[1]  = '{6'd1, 32'd3,          32'd3,          32'd0,          32'd0,          1'b0};
        vecs[2]  = '{6'd1, 32'd0,          32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[3]  = '{6'd2, 32'h00010000,   32'h00010000,   32'd0,          32'd1,          1'b0};
        vecs[4]  = '{6'd2, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE,   32'd1,          1'b0};
        vecs[5]  = '{6'd3, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[6]  = '{6'd3, 32'd9,          32'd0,          32'hFFFFFFFF,   32'd9,          1'b1};
        vecs[7]  = '{6'd0, 32'd1,          32'd1,          32'd2,          32'd0,          1'b0};
        vecs[8]  = '{6'd7, 32'hFFFFFFFF,   32'd1,          32'd1,          32'd0,          1'b0};
        vecs[9]  = '{6'd7, 32'd1,          32'hFFFFFFFF,   32'd0,          32'd0,          1'b0};
        vecs[10] = '{6'd6, 32'h0F0F0F0F,   32'h12345678,   32'hF0F0F0F0,   32'd0,          1'b0};
        vecs[11] = '{6'd9, 32'd2,          32'd3,          32'd5,          32'd0,          1'b0};
        vecs[12] = '{6'd4, 32'hF0F00000,   32'h0000F0F0,   32'hF0F0F0F0,   32'd0,          1'b0};
        vecs[13] = '{6'd5, 32'hFF00FF00,   32'h0FF00FF0,   32'h0F000F00,   32'd0,          1'b0};
        vecs[14] = '{6'd3, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[15] = '{6'd2, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'hFFFFFFFE,   1'b0};

        Reset_n = 1'b0; Start = 1'b0; ALU_Ctrl = 6'd0; A = '0; B = '0;
        #1;
        chk("reset_outputs", {Busy, Done, Zero, Div_Zero, Result, Result_Hi}, '0);
        repeat (2) @(posedge Clock);
        #1 Reset_n = 1'b1;
        @(posedge Clock); #1;

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b,
                   mk_exp(vecs[i].code, vecs[i].b, vecs[i].res, vecs[i].hi, vecs[i].dz));
        end

        for (int i = 0; i < 24; i++) begin
            rc = 6'($urandom_range(0, 15));
            ra = $urandom;
            rb = (rc == 6'd3 && $urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom);
            run_op($sformatf("rnd%0d", i), rc, ra, rb, model(rc, ra, rb));
        end

        // Start mid-multiply is ignored; Start in the Done cycle is accepted.
        sb_q.push_back(mk_exp(6'd2, 32'h00010000, 32'd0, 32'd1, 1'b0));
        Start = 1'b1; ALU_Ctrl = 6'd2; A = 32'h00010000; B = 32'h00010000;
        @(posedge Clock); #1;
        Start = 1'b0;
        lat = 1;
        dones = 0;
        repeat (4) begin
            if (Done) dones++;
            @(posedge Clock); #1;
            lat++;
        end
        Start = 1'b1; ALU_Ctrl = 6'd0; A = 32'd1; B = 32'd1;
        @(posedge Clock); #1;
        Start = 1'b0; A = 32'd77; B = 32'd0;
        lat++;
        busy = lat - 1;
        while (!Done && lat < 3 * W) begin
            if (Busy) busy++;
            @(posedge Clock); #1;
            lat++;
        end
        chk("hs_no_early_done", dones, 0);
        compare_out("hs_mult", lat, busy);
        sb_q.push_back(mk_exp(6'd0, 32'd22, 32'd42, 32'd0, 1'b0));
        Start = 1'b1; ALU_Ctrl = 6'd0; A = 32'd20; B = 32'd22;
        @(posedge Clock); #1;
        Start = 1'b0;
        chk("hs_b2b_done", Done, 1'b1);
        compare_out("hs_b2b", 1, 0);
        @(posedge Clock); #1;
        chk("hs_done_one_cycle", Done, 1'b0);

        // Reset during a divide aborts it immediately with no Done.
        Start = 1'b1; ALU_Ctrl = 6'd3; A = 32'd1000; B = 32'd3;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (9) @(posedge Clock);
        #1;
        chk("rst_busy_before", Busy, 1'b1);
        Reset_n = 1'b0;
        #1;
        chk("rst_outputs_async", {Busy, Done, Zero, Div_Zero, Result, Result_Hi}, '0);
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        dones = 0;
        repeat (W + 4) begin
            if (Done || Busy) dones++;
            @(posedge Clock); #1;
        end
        chk("rst_no_done", dones, 0);
        run_op("rst_add", 6'd0, 32'd40, 32'd2, mk_exp(6'd0, 32'd2, 32'd42, 32'd0, 1'b0));
        chk("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
